// File: rtl/key_schedule_gen.sv
// Word-serial AES-128/192/256 key expansion into a round-key buffer that the
// cipher datapath reads by round index, one 128-bit round key per cycle.
module key_schedule_gen #(
    parameter int MAX_NK  = 8,
    parameter bit RD_ZERO = 1'b1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         start_i,
    input  logic [1:0]   key_len_i,
    input  logic [255:0] key_i,
    output logic         busy_o,
    output logic         done_o,
    output logic         ready_o,
    output logic         err_o,
    input  logic         rd_en_i,
    input  logic [3:0]   rd_round_i,
    output logic [127:0] rd_key_o,
    output logic         rd_valid_o
);
    localparam int         DEPTH    = 4 * (MAX_NK + 7);
    localparam logic [3:0] MAX_NK_W = 4'(MAX_NK);

    typedef enum logic [1:0] {IDLE, EXPAND, READY} state_e;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] x;
        acc = 8'h00;
        x   = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) acc = acc ^ x;
            x = xtime(x);
        end
        return acc;
    endfunction

    // S-box as GF(2^8) inverse (a^254 by an addition chain) plus the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] x2, x3, x12, x15, x240, inv;
        x2   = gf_mul(a, a);
        x3   = gf_mul(x2, a);
        x12  = gf_mul(x3, x3);
        x12  = gf_mul(x12, x12);
        x15  = gf_mul(x12, x3);
        x240 = x15;
        for (int k = 0; k < 4; k++) x240 = gf_mul(x240, x240);
        inv  = gf_mul(gf_mul(x240, x12), x2);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [31:0] key_word(input logic [255:0] key, input logic [3:0] j);
        logic [255:0] s;
        s = key << (32 * int'(j));
        return s[255:224];
    endfunction

    state_e       state_q, state_d;
    logic [3:0]   nk_q, nk_d;
    logic [5:0]   i_q, i_d;
    logic [3:0]   phase_q, phase_d;
    logic [7:0]   rcon_q, rcon_d;
    logic         done_q, done_d;
    logic         err_q, err_d;
    logic [31:0]  win_q [MAX_NK];
    logic [31:0]  win_d [MAX_NK];
    logic [31:0]  buf_q [DEPTH];
    logic         rd_valid_q;
    logic [127:0] rd_key_q;

    logic [3:0]   nk_new, nr;
    logic         key_ok, accept, expand, rd_hit;
    logic [31:0]  head, tail, sub_in, sub_out, t_word, w_new;
    logic [5:0]   last_idx, rd_base;

    always_comb begin
        case (key_len_i)
            2'b00:   nk_new = 4'd4;
            2'b01:   nk_new = 4'd6;
            2'b10:   nk_new = 4'd8;
            default: nk_new = 4'd0;
        endcase
    end

    assign key_ok   = (nk_new != 4'd0) && (nk_new <= MAX_NK_W);
    assign accept   = start_i && (state_q != EXPAND) && key_ok;
    assign expand   = (state_q == EXPAND);
    assign last_idx = {nk_q, 2'b00} + 6'd27;
    assign nr       = nk_q + 4'd6;

    // Window: entry 0 holds w[i-1], entry Nk-1 holds w[i-Nk].
    assign head = win_q[0];
    always_comb begin
        tail = win_q[0];
        for (int k = 0; k < MAX_NK; k++)
            if (4'(k) == nk_q - 4'd1) tail = win_q[k];
    end

    assign sub_in  = (phase_q == 4'd0) ? {head[23:0], head[31:24]} : head;
    assign sub_out = sub_word(sub_in);

    always_comb begin
        t_word = head;
        if (phase_q == 4'd0)                       t_word = sub_out ^ {rcon_q, 24'h0};
        else if (nk_q == 4'd8 && phase_q == 4'd4)  t_word = sub_out;
    end

    assign w_new = tail ^ t_word;

    // NOTE: every variable gets its default before the case so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        nk_d    = nk_q;
        i_d     = i_q;
        phase_d = phase_q;
        rcon_d  = rcon_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        win_d   = win_q;
        case (state_q)
            IDLE, READY: begin
                if (accept) begin
                    nk_d    = nk_new;
                    i_d     = {2'b00, nk_new};
                    phase_d = 4'd0;
                    rcon_d  = 8'h01;
                    state_d = EXPAND;
                    for (int k = 0; k < MAX_NK; k++) begin
                        win_d[k] = '0;
                        if (4'(k) < nk_new) win_d[k] = key_word(key_i, nk_new - 4'd1 - 4'(k));
                    end
                end else if (start_i) begin
                    err_d = 1'b1;
                end
            end
            EXPAND: begin
                win_d[0] = w_new;
                for (int k = 1; k < MAX_NK; k++) win_d[k] = win_q[k-1];
                if (phase_q == 4'd0) rcon_d = xtime(rcon_q);
                phase_d = (phase_q == nk_q - 4'd1) ? 4'd0 : phase_q + 4'd1;
                i_d     = i_q + 6'd1;
                if (i_q == last_idx) begin
                    done_d  = 1'b1;
                    state_d = READY;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of the others.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            nk_q    <= '0;
            i_q     <= '0;
            phase_q <= '0;
            rcon_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            nk_q    <= nk_d;
            i_q     <= i_d;
            phase_q <= phase_d;
            rcon_q  <= rcon_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // NOTE: window and buffer carry no reset; nothing is readable until a new
    // expansion has rewritten every entry that the read guard can reach.
    always_ff @(posedge clk_i) begin
        win_q <= win_d;
        if (accept) begin
            for (int j = 0; j < MAX_NK; j++)
                if (4'(j) < nk_new) buf_q[j] <= key_word(key_i, 4'(j));
        end else if (expand) begin
            buf_q[i_q] <= w_new;
        end
    end

    assign rd_hit  = rd_en_i && (state_q == READY) && (rd_round_i <= nr);
    assign rd_base = {rd_round_i, 2'b00};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_valid_q <= 1'b0;
            rd_key_q   <= '0;
        end else if (rd_hit) begin
            rd_valid_q <= 1'b1;
            rd_key_q   <= {buf_q[rd_base], buf_q[rd_base + 6'd1],
                           buf_q[rd_base + 6'd2], buf_q[rd_base + 6'd3]};
        end else begin
            rd_valid_q <= 1'b0;
            if (RD_ZERO) rd_key_q <= '0;
        end
    end

    assign busy_o     = (state_q == EXPAND);
    assign ready_o    = (state_q == READY);
    assign done_o     = done_q;
    assign err_o      = err_q;
    assign rd_valid_o = rd_valid_q;
    assign rd_key_o   = rd_key_q;
endmodule

// File: tb/tb_key_schedule_gen.sv
// Directed bench for key_schedule_gen using FIPS-197 key expansion vectors;
// a second instance with MAX_NK=6, RD_ZERO=0 covers the rejection and hold cases.
module tb_key_schedule_gen;
    localparam logic [127:0] K128_HI = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [255:0] K128    = {K128_HI, 128'hdeadbeef_0badf00d_12345678_9abcdef0};
    localparam logic [255:0] K192    = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b,
                                        64'hcafef00d_55aa55aa};
    localparam logic [255:0] K256    = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] R1_128  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] R10_128 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] R0_192  = 128'h8e73b0f7da0e6452c810f32b809079e5;
    localparam logic [127:0] R1_192  = 128'h62f8ead2522c6b7bfe0c91f72402f5a5;
    localparam logic [127:0] R12_192 = 128'he98ba06f448c773c8ecc720401002202;
    localparam logic [127:0] R0_256  = 128'h603deb1015ca71be2b73aef0857d7781;
    localparam logic [127:0] R1_256  = 128'h1f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] R2_256  = 128'h9ba354118e6925afa51a8b5f2067fcde;
    localparam logic [127:0] R3_256  = 128'ha8b09c1a93d194cdbe49846eb75d5b9a;
    localparam logic [127:0] R14_256 = 128'hfe4890d1e6188d0b046df344706c631e;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, start, start6, rd_en;
    logic [1:0]   key_len;
    logic [255:0] key;
    logic [3:0]   rd_round;
    logic         busy, done, ready, err, rd_valid;
    logic [127:0] rd_key;
    logic         busy6, done6, ready6, err6, rd_valid6;
    logic [127:0] rd_key6;

    int n_cmp;
    int n_fail;

    key_schedule_gen #(.MAX_NK(8), .RD_ZERO(1'b1)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .key_len_i(key_len), .key_i(key),
        .busy_o(busy), .done_o(done), .ready_o(ready), .err_o(err),
        .rd_en_i(rd_en), .rd_round_i(rd_round), .rd_key_o(rd_key), .rd_valid_o(rd_valid)
    );

    key_schedule_gen #(.MAX_NK(6), .RD_ZERO(1'b0)) dut6 (
        .clk_i(clk), .rst_i(rst), .start_i(start6), .key_len_i(key_len), .key_i(key),
        .busy_o(busy6), .done_o(done6), .ready_o(ready6), .err_o(err6),
        .rd_en_i(rd_en), .rd_round_i(rd_round), .rd_key_o(rd_key6), .rd_valid_o(rd_valid6)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_key(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic read_round(input logic [3:0] r);
        rd_en    = 1'b1;
        rd_round = r;
        tick();
        rd_en    = 1'b0;
    endtask

    task automatic launch(input logic [1:0] len, input logic [255:0] k);
        key_len = len;
        key     = k;
        start   = 1'b1;
        tick();
        start   = 1'b0;
    endtask

    task automatic wait_done(input int exp_cycles, input string tag);
        int n = 0;
        while (done !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        check_int(tag, n, exp_cycles);
    endtask

    task automatic wait_done6(input int exp_cycles, input string tag);
        int n = 0;
        while (done6 !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        check_int(tag, n, exp_cycles);
    endtask

    initial begin
        int cnt;
        int err_seen;
        int done_seen;
        n_cmp    = 0;
        n_fail   = 0;
        rst      = 1'b1;
        start    = 1'b0;
        start6   = 1'b0;
        rd_en    = 1'b0;
        rd_round = 4'd0;
        key_len  = 2'b00;
        key      = '0;
        tick();
        tick();
        check_bit("rst_busy", busy, 1'b0);
        check_bit("rst_done", done, 1'b0);
        check_bit("rst_ready", ready, 1'b0);
        check_bit("rst_err", err, 1'b0);
        check_bit("rst_rd_valid", rd_valid, 1'b0);
        check_key("rst_rd_key", rd_key, 128'h0);
        rst = 1'b0;
        tick();

        // AES-128, junk in the unused low key bits
        launch(2'b00, K128);
        check_bit("a128_busy", busy, 1'b1);
        check_bit("a128_ready_low", ready, 1'b0);
        wait_done(40, "a128_done_latency");
        check_bit("a128_ready", ready, 1'b1);
        check_bit("a128_busy_end", busy, 1'b0);
        tick();
        check_bit("a128_done_pulse", done, 1'b0);
        read_round(4'd0);
        check_bit("a128_r0_valid", rd_valid, 1'b1);
        check_key("a128_r0", rd_key, K128_HI);
        read_round(4'd1);
        check_key("a128_r1", rd_key, R1_128);
        read_round(4'd10);
        check_key("a128_r10", rd_key, R10_128);
        read_round(4'd13);
        check_bit("a128_r13_valid", rd_valid, 1'b0);
        check_key("a128_r13_zero", rd_key, 128'h0);

        // illegal key_len from READY
        launch(2'b11, K128);
        check_bit("ill_err", err, 1'b1);
        check_bit("ill_busy", busy, 1'b0);
        check_bit("ill_ready_kept", ready, 1'b1);
        tick();
        check_bit("ill_err_pulse", err, 1'b0);

        // AES-192
        launch(2'b01, K192);
        wait_done(46, "a192_done_latency");
        read_round(4'd0);
        check_key("a192_r0", rd_key, R0_192);
        read_round(4'd1);
        check_key("a192_r1", rd_key, R1_192);
        read_round(4'd12);
        check_key("a192_r12", rd_key, R12_192);

        // AES-256 and back-to-back reverse reads
        launch(2'b10, K256);
        wait_done(52, "a256_done_latency");
        read_round(4'd2);
        check_key("a256_r2", rd_key, R2_256);
        read_round(4'd3);
        check_key("a256_r3", rd_key, R3_256);
        read_round(4'd1);
        check_key("a256_r1", rd_key, R1_256);
        cnt   = 0;
        rd_en = 1'b1;
        for (int r = 14; r >= 0; r--) begin
            rd_round = 4'(r);
            tick();
            if (rd_valid === 1'b1) cnt++;
            if (r == 14) check_key("b2b_r14", rd_key, R14_256);
        end
        rd_en = 1'b0;
        check_int("b2b_valid_count", cnt, 15);
        check_key("b2b_r0", rd_key, R0_256);

        // restart with a read in the same cycle: the old schedule is returned
        key_len  = 2'b00;
        key      = K128;
        start    = 1'b1;
        rd_en    = 1'b1;
        rd_round = 4'd14;
        tick();
        start    = 1'b0;
        rd_en    = 1'b0;
        check_bit("rs_old_valid", rd_valid, 1'b1);
        check_key("rs_old_key", rd_key, R14_256);
        check_bit("rs_ready_low", ready, 1'b0);
        read_round(4'd0);
        check_bit("rs_read_blocked", rd_valid, 1'b0);
        check_key("rs_read_zero", rd_key, 128'h0);
        wait_done(39, "rs_done_latency");
        read_round(4'd10);
        check_key("rs_r10", rd_key, R10_128);

        // start held high throughout an AES-256 expansion
        launch(2'b10, K256);
        key_len  = 2'b00;
        cnt      = 0;
        err_seen = 0;
        while (done !== 1'b1 && cnt < 200) begin
            start = 1'b1;
            tick();
            cnt++;
            if (err === 1'b1) err_seen++;
        end
        start = 1'b0;
        check_int("spam_done_latency", cnt, 52);
        check_int("spam_no_err", err_seen, 0);
        read_round(4'd14);
        check_key("spam_r14", rd_key, R14_256);

        // reset in the middle of an expansion
        launch(2'b10, K256);
        repeat (19) tick();
        rst = 1'b1;
        tick();
        check_bit("mid_rst_busy", busy, 1'b0);
        check_bit("mid_rst_ready", ready, 1'b0);
        rst       = 1'b0;
        done_seen = 0;
        repeat (60) begin
            tick();
            if (done === 1'b1) done_seen++;
        end
        check_int("mid_rst_no_done", done_seen, 0);
        launch(2'b00, K128);
        wait_done(40, "post_rst_done_latency");
        read_round(4'd10);
        check_key("post_rst_r10", rd_key, R10_128);

        // MAX_NK=6 instance: AES-256 rejected, AES-192 works, RD_ZERO=0 holds
        key_len = 2'b10;
        key     = K256;
        start6  = 1'b1;
        tick();
        start6  = 1'b0;
        check_bit("nk6_err", err6, 1'b1);
        check_bit("nk6_busy", busy6, 1'b0);
        key_len = 2'b01;
        key     = K192;
        start6  = 1'b1;
        tick();
        start6  = 1'b0;
        wait_done6(46, "nk6_a192_done_latency");
        read_round(4'd12);
        check_bit("nk6_r12_valid", rd_valid6, 1'b1);
        check_key("nk6_r12", rd_key6, R12_192);
        read_round(4'd13);
        check_bit("nk6_r13_valid", rd_valid6, 1'b0);
        check_key("nk6_r13_hold", rd_key6, R12_192);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
